// File: rtl/icache_ctrl.sv
// icache_ctrl: fetch sequencer for a 64-line direct-mapped instruction cache.
// It handles one fetch at a time: lookup, then on a miss a memory read and a
// line refill, then the response to the IFU. It also supports cache bypass
// and keeps saturating hit/miss counters.
module icache_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cache_en,
   input  logic             ifu_req_valid,
   output logic             ifu_req_ready,
   input  logic [29:0]      ifu_addr,
   output logic             ifu_resp_valid,
   input  logic             ifu_resp_ready,
   output logic [31:0]      ifu_resp_data,
   output logic             ifu_resp_err,
   output logic             ic_req_valid,
   output logic             ic_wen,
   output logic [29:0]      ic_addr,
   output logic [31:0]      ic_wdata,
   input  logic             ic_is_hit,
   input  logic [31:0]      ic_rdata,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [31:0]      mem_addr,
   input  logic             mem_resp_valid,
   input  logic [31:0]      mem_resp_data,
   input  logic             mem_resp_err,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOOKUP   = 3'd1;
   localparam logic [2:0] S_MEM_REQ  = 3'd2;
   localparam logic [2:0] S_MEM_WAIT = 3'd3;
   localparam logic [2:0] S_FILL     = 3'd4;
   localparam logic [2:0] S_RESP     = 3'd5;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The response buffer holds either the hit data or the memory return.
   // It also supplies the refill data, so FILL needs no extra register.
   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic [2:0]  state, state_nxt;
   logic [29:0] addr_q;
   logic        en_q;
   resp_t       resp_q;

   // Next-state selection. Memory responses are only consumed in MEM_WAIT,
   // so a stale response that arrives after a reset is dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (ifu_req_valid) state_nxt = cache_en ? S_LOOKUP : S_MEM_REQ;
         S_LOOKUP:   state_nxt = ic_is_hit ? S_RESP : S_MEM_REQ;
         S_MEM_REQ:  if (mem_req_ready) state_nxt = S_MEM_WAIT;
         S_MEM_WAIT: if (mem_resp_valid)
                        state_nxt = (mem_resp_err || !en_q) ? S_RESP : S_FILL;
         S_FILL:     state_nxt = S_RESP;
         S_RESP:     if (ifu_resp_ready) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Request latch and response buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= '0;
         en_q   <= 1'b0;
         resp_q <= '0;
      end else begin
         if (state == S_IDLE && ifu_req_valid) begin
            addr_q <= ifu_addr;
            en_q   <= cache_en;
         end
         if (state == S_LOOKUP && ic_is_hit)
            resp_q <= '{data: ic_rdata, err: 1'b0};
         if (state == S_MEM_WAIT && mem_resp_valid)
            resp_q <= '{data: mem_resp_data, err: mem_resp_err};
      end
   end

   // Saturating hit/miss counters. They only advance on a lookup, so bypass
   // fetches never touch them.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == S_LOOKUP) begin
         if (ic_is_hit) begin
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
         end else begin
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
         end
      end
   end

   // All outputs decode from state or registers. Lookup and fill are
   // separate states, so ic_req_valid and ic_wen can never be high together.
   assign ifu_req_ready  = (state == S_IDLE);
   assign ifu_resp_valid = (state == S_RESP);
   assign ifu_resp_data  = resp_q.data;
   assign ifu_resp_err   = resp_q.err;
   assign ic_req_valid   = (state == S_LOOKUP);
   assign ic_wen         = (state == S_FILL);
   assign ic_addr        = addr_q;
   assign ic_wdata       = resp_q.data;
   assign mem_req_valid  = (state == S_MEM_REQ);
   assign mem_addr       = {addr_q, 2'b00};

endmodule
